// File: rtl/fpmul_issue_ctrl.sv
// ----------------------------------------------------------------------------
// fpmul_issue_ctrl
//
// Purpose:
//   Sits in front of a multi-cycle floating-point multiplier (FPMUL). Operand
//   pairs are buffered in a small FIFO, then issued one at a time. For each
//   pair the controller pulses Start, waits a bounded number of cycles for
//   Done, captures the product and flags, and holds them for a downstream
//   consumer using a valid/ready handshake. If Done never arrives, the
//   operation is dropped and a sticky Timeout flag is raised.
//
// Parameters:
//   DEPTH    operand-pair FIFO depth (power of 2, >= 2)
//   TIMEOUT  maximum number of WAIT cycles allowed for Mul_Done (2..31)
//
// Ports:
//   Clk        clock, all state changes on the rising edge
//   Rst        synchronous active-high reset
//   In_Valid   operand pair offered by the producer
//   In_A/In_B  operand pair (32-bit each)
//   In_Ready   FIFO has room for another pair
//   Mul_A/B    operands presented to the multiplier, held until next pop
//   Mul_Start  one-cycle start pulse to the multiplier
//   Mul_Done   multiplier completion strobe
//   Mul_P      multiplier product
//   Mul_Flags  multiplier flags {OF,UF,NaNF,InfF,DNF,ZF}
//   Out_Valid  captured result is available
//   Out_Ready  consumer accepts the result
//   Out_P      captured product
//   Out_Flags  captured flags, same bit order as Mul_Flags
//   Timeout    sticky: some operation received no Mul_Done in time
//   Busy       FSM not idle or FIFO holds pairs
// ----------------------------------------------------------------------------
module fpmul_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst,

    input  logic        In_Valid,
    input  logic [31:0] In_A,
    input  logic [31:0] In_B,
    output logic        In_Ready,

    output logic [31:0] Mul_A,
    output logic [31:0] Mul_B,
    output logic        Mul_Start,
    input  logic        Mul_Done,
    input  logic [31:0] Mul_P,
    input  logic [5:0]  Mul_Flags,

    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Out_P,
    output logic [5:0]  Out_Flags,

    output logic        Timeout,
    output logic        Busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // The wait counter is cleared on entry to WAIT and counts WAIT cycles
    // that saw no Done. When it sits at TIMEOUT-1 with still no Done, this
    // is the TIMEOUT-th empty WAIT cycle and the operation is abandoned.
    localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0] fifo_a [DEPTH];
    logic [31:0] fifo_b [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [4:0]       wait_cnt;

    logic fifo_empty;
    logic push;
    logic pop;

    logic start_pulse;
    logic capture;
    logic timeout_hit;
    logic clear_wait;
    logic inc_wait;

    // ------------------------------------------------------------------
    // FIFO status. In_Ready deliberately ignores a pop in the same cycle
    // so that the ready path never depends on FSM decode.
    // ------------------------------------------------------------------
    assign fifo_empty = (count == '0);
    assign In_Ready   = (count < DEPTH_CNT);
    assign push       = In_Valid && In_Ready;

    // ------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control decode. Mul_Done only matters in WAIT;
    // a Done strobe seen in any other state has no effect.
    // ------------------------------------------------------------------
    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        start_pulse = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        clear_wait  = 1'b0;
        inc_wait    = 1'b0;

        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = S_ISSUE;
                end
            end

            S_ISSUE: begin
                start_pulse = 1'b1;
                clear_wait  = 1'b1;
                next_state  = S_WAIT;
            end

            S_WAIT: begin
                if (Mul_Done) begin
                    capture    = 1'b1;
                    next_state = S_OUT;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = S_IDLE;
                end else begin
                    inc_wait = 1'b1;
                end
            end

            S_OUT: begin
                if (Out_Ready) begin
                    next_state = S_IDLE;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    assign Mul_Start = start_pulse;
    assign Out_Valid = (state == S_OUT);
    assign Busy      = (state != S_IDLE) || !fifo_empty;

    // ------------------------------------------------------------------
    // FIFO storage. Contents need no reset: the occupancy count decides
    // what is valid, and it is cleared by Rst.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= In_A;
            fifo_b[wr_ptr] <= In_B;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy. DEPTH is a power of two, so the
    // pointers wrap naturally at their width. A push and pop in the same
    // cycle leave the count unchanged.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand registers toward the multiplier. They are loaded only on a
    // pop, so they stay stable for the whole multiply.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Mul_A <= '0;
            Mul_B <= '0;
        end else if (pop) begin
            Mul_A <= fifo_a[rd_ptr];
            Mul_B <= fifo_b[rd_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Wait counter for the Done timeout.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wait_cnt <= '0;
        end else if (clear_wait) begin
            wait_cnt <= '0;
        end else if (inc_wait) begin
            wait_cnt <= wait_cnt + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Result capture. Only the WAIT-state Done loads these registers, so
    // they hold steady through OUT no matter what the multiplier does.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Out_P     <= '0;
            Out_Flags <= '0;
        end else if (capture) begin
            Out_P     <= Mul_P;
            Out_Flags <= Mul_Flags;
        end
    end

    // ------------------------------------------------------------------
    // Sticky timeout flag; only Rst clears it.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Timeout <= 1'b0;
        end else if (timeout_hit) begin
            Timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fpmul_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fpmul_issue_ctrl
//
// Directed bench for fpmul_issue_ctrl. A behavioural multiplier stand-in
// answers each Start with Done four cycles later (unless disabled), returning
// a hand-tabulated product/flags for known operand pairs. A second source can
// inject stray Done strobes. Inputs are driven and outputs sampled on the
// falling clock edge.
// ----------------------------------------------------------------------------
module tb_fpmul_issue_ctrl;

    logic        Clk;
    logic        Rst;
    logic        In_Valid;
    logic [31:0] In_A;
    logic [31:0] In_B;
    logic        In_Ready;
    logic [31:0] Mul_A;
    logic [31:0] Mul_B;
    logic        Mul_Start;
    logic        Mul_Done;
    logic [31:0] Mul_P;
    logic [5:0]  Mul_Flags;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_P;
    logic [5:0]  Out_Flags;
    logic        Timeout;
    logic        Busy;

    logic        model_done;
    logic [31:0] model_p;
    logic [5:0]  model_flags;
    logic        spur_done;
    logic [31:0] spur_p;
    logic [5:0]  spur_flags;
    logic        resp_enable;

    int countdown;
    int start_count;
    int base_starts;
    int checks_total;
    int checks_passed;

    logic [31:0] fill_a [5] = '{32'h40000000, 32'h40400000, 32'h7F000000, 32'h00000000, 32'hBF800000};
    logic [31:0] fill_b [5] = '{32'h40000000, 32'h40000000, 32'h7F000000, 32'h40000000, 32'h40000000};
    logic [31:0] fill_p [5] = '{32'h40800000, 32'h40C00000, 32'h7F800000, 32'h00000000, 32'hC0000000};
    logic [5:0]  fill_f [5] = '{6'h00, 6'h00, 6'h24, 6'h01, 6'h00};

    assign Mul_Done  = model_done | spur_done;
    assign Mul_P     = spur_done ? spur_p : model_p;
    assign Mul_Flags = spur_done ? spur_flags : model_flags;

    fpmul_issue_ctrl #(
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Valid  (In_Valid),
        .In_A      (In_A),
        .In_B      (In_B),
        .In_Ready  (In_Ready),
        .Mul_A     (Mul_A),
        .Mul_B     (Mul_B),
        .Mul_Start (Mul_Start),
        .Mul_Done  (Mul_Done),
        .Mul_P     (Mul_P),
        .Mul_Flags (Mul_Flags),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_P     (Out_P),
        .Out_Flags (Out_Flags),
        .Timeout   (Timeout),
        .Busy      (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Hand-tabulated multiplier results {flags, product} for the operand
    // pairs the bench uses; flags are {OF,UF,NaNF,InfF,DNF,ZF}.
    function automatic logic [37:0] fpmulModel(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return {6'h00, 32'h40000000};
            64'h40000000_40000000: return {6'h00, 32'h40800000};
            64'h40400000_40000000: return {6'h00, 32'h40C00000};
            64'h7F000000_7F000000: return {6'h24, 32'h7F800000};
            64'h00000000_40000000: return {6'h01, 32'h00000000};
            64'hBF800000_40000000: return {6'h00, 32'hC0000000};
            64'h40800000_3F000000: return {6'h00, 32'h40000000};
            64'h3FC00000_40000000: return {6'h00, 32'h40400000};
            64'h40A00000_40000000: return {6'h00, 32'h41200000};
            64'h40E00000_40000000: return {6'h00, 32'h41600000};
            64'h41000000_41000000: return {6'h00, 32'h42800000};
            default:               return {6'h3F, 32'hFFFFFFFF};
        endcase
    endfunction

    // Multiplier stand-in: Done is high during the fourth cycle after the
    // Start cycle, with the tabulated result for the operands on Mul_A/B.
    initial begin
        model_done  = 1'b0;
        model_p     = '0;
        model_flags = '0;
        countdown   = 0;
        forever begin
            @(negedge Clk);
            model_done = 1'b0;
            if (countdown > 0) begin
                countdown = countdown - 1;
                if (countdown == 0) begin
                    {model_flags, model_p} = fpmulModel(Mul_A, Mul_B);
                    model_done = 1'b1;
                end
            end
            if (Mul_Start && resp_enable) begin
                countdown = 4;
            end
        end
    end

    initial start_count = 0;
    always @(posedge Clk) begin
        if (Mul_Start) begin
            start_count <= start_count + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] a,
                                 input logic [31:0] b, input logic ready);
        In_Valid  = valid;
        In_A      = a;
        In_B      = b;
        Out_Ready = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total = checks_total + 1;
        assert (observed === expected) checks_passed = checks_passed + 1;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    task automatic waitOutValid(input string tag, input int budget);
        int n;
        n = 0;
        while (!Out_Valid && n < budget) begin
            step(1);
            n = n + 1;
        end
        checkOutput(tag, 32'(Out_Valid), 32'd1);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        resp_enable   = 1'b1;
        spur_done     = 1'b0;
        spur_p        = '0;
        spur_flags    = '0;
        Rst           = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        step(2);

        // Reset state
        checkOutput("rst_in_ready",  32'(In_Ready),  32'd1);
        checkOutput("rst_busy",      32'(Busy),      32'd0);
        checkOutput("rst_out_valid", 32'(Out_Valid), 32'd0);
        checkOutput("rst_mul_start", 32'(Mul_Start), 32'd0);
        checkOutput("rst_timeout",   32'(Timeout),   32'd0);
        checkOutput("rst_out_p",     Out_P,          32'h0);
        Rst = 1'b0;

        // Single operation, pushed at edge 0, consumer stalled
        base_starts = start_count;
        applyStimulus(1'b1, 32'h3F800000, 32'h40000000, 1'b0);
        step(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("single_busy_e0",  32'(Busy),      32'd1);
        checkOutput("single_start_e0", 32'(Mul_Start), 32'd0);
        step(1);
        checkOutput("single_start_e1", 32'(Mul_Start), 32'd1);
        checkOutput("single_mul_a",    Mul_A,          32'h3F800000);
        checkOutput("single_mul_b",    Mul_B,          32'h40000000);
        step(1);
        checkOutput("single_start_e2", 32'(Mul_Start), 32'd0);
        step(3);
        checkOutput("single_valid_e5", 32'(Out_Valid), 32'd0);
        step(1);
        checkOutput("single_valid_e6", 32'(Out_Valid), 32'd1);
        checkOutput("single_out_p",    Out_P,          32'h40000000);
        checkOutput("single_flags",    32'(Out_Flags), 32'h0);
        checkOutput("single_nstarts",  32'(start_count - base_starts), 32'd1);

        // Backpressure for 10 cycles with a stray Done while in OUT
        step(3);
        spur_p     = 32'h12345678;
        spur_flags = 6'h3F;
        spur_done  = 1'b1;
        step(1);
        spur_done  = 1'b0;
        step(6);
        checkOutput("bp_valid",   32'(Out_Valid), 32'd1);
        checkOutput("bp_out_p",   Out_P,          32'h40000000);
        checkOutput("bp_flags",   32'(Out_Flags), 32'h0);
        checkOutput("bp_nstarts", 32'(start_count - base_starts), 32'd1);

        // Fill the FIFO while the FSM is stalled in OUT
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, fill_a[i], fill_b[i], 1'b0);
            step(1);
            if (i == 2) begin
                checkOutput("fill_ready_3", 32'(In_Ready), 32'd1);
            end
        end
        checkOutput("fill_ready_4", 32'(In_Ready), 32'd0);
        applyStimulus(1'b1, fill_a[4], fill_b[4], 1'b0);
        step(2);
        checkOutput("fill_held_ready", 32'(In_Ready), 32'd0);
        checkOutput("fill_held_outp",  Out_P,          32'h40000000);
        checkOutput("fill_nstarts",    32'(start_count - base_starts), 32'd1);

        // Release the consumer; the held fifth pair enters once a slot frees
        applyStimulus(1'b1, fill_a[4], fill_b[4], 1'b1);
        step(1);
        checkOutput("drain_valid_e1", 32'(Out_Valid), 32'd0);
        checkOutput("drain_ready_e1", 32'(In_Ready),  32'd0);
        step(1);
        checkOutput("drain_start_e2", 32'(Mul_Start), 32'd1);
        checkOutput("drain_mul_a_e2", Mul_A,          fill_a[0]);
        checkOutput("drain_ready_e2", 32'(In_Ready),  32'd1);
        step(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("drain_ready_e3", 32'(In_Ready),  32'd0);
        for (int i = 0; i < 5; i++) begin
            waitOutValid("drain_wait", 20);
            checkOutput("drain_out_p", Out_P,          fill_p[i]);
            checkOutput("drain_flags", 32'(Out_Flags), 32'(fill_f[i]));
            step(1);
        end
        step(3);
        checkOutput("drain_busy", 32'(Busy), 32'd0);

        // Timeout: first pair never gets Done, second runs normally
        resp_enable = 1'b0;
        applyStimulus(1'b1, 32'h41000000, 32'h41000000, 1'b1);
        step(1);
        applyStimulus(1'b1, 32'h40800000, 32'h3F000000, 1'b1);
        step(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("to_start",   32'(Mul_Start), 32'd1);
        checkOutput("to_mul_a",   Mul_A,          32'h41000000);
        step(16);
        checkOutput("to_flag_e17",  32'(Timeout),   32'd0);
        checkOutput("to_valid_e17", 32'(Out_Valid), 32'd0);
        step(1);
        checkOutput("to_flag_e18",  32'(Timeout),   32'd1);
        checkOutput("to_valid_e18", 32'(Out_Valid), 32'd0);
        checkOutput("to_busy_e18",  32'(Busy),      32'd1);
        resp_enable = 1'b1;
        step(1);
        checkOutput("to_next_start", 32'(Mul_Start), 32'd1);
        checkOutput("to_next_mul_a", Mul_A,          32'h40800000);
        checkOutput("to_next_mul_b", Mul_B,          32'h3F000000);
        waitOutValid("to_next_wait", 20);
        checkOutput("to_next_out_p", Out_P,          32'h40000000);
        checkOutput("to_sticky",     32'(Timeout),   32'd1);
        step(3);
        checkOutput("to_busy_end",   32'(Busy),      32'd0);

        // Reset in WAIT with two pairs queued
        applyStimulus(1'b1, 32'h3FC00000, 32'h40000000, 1'b1);
        step(1);
        applyStimulus(1'b1, 32'h40A00000, 32'h40000000, 1'b1);
        step(1);
        applyStimulus(1'b1, 32'h40E00000, 32'h40000000, 1'b1);
        step(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("mid_busy",  32'(Busy),  32'd1);
        checkOutput("mid_mul_a", Mul_A,      32'h3FC00000);
        Rst = 1'b1;
        step(1);
        Rst = 1'b0;
        base_starts = start_count;
        checkOutput("mrst_out_valid", 32'(Out_Valid), 32'd0);
        checkOutput("mrst_mul_start", 32'(Mul_Start), 32'd0);
        checkOutput("mrst_mul_a",     Mul_A,          32'h0);
        checkOutput("mrst_mul_b",     Mul_B,          32'h0);
        checkOutput("mrst_out_p",     Out_P,          32'h0);
        checkOutput("mrst_flags",     32'(Out_Flags), 32'h0);
        checkOutput("mrst_timeout",   32'(Timeout),   32'd0);
        checkOutput("mrst_in_ready",  32'(In_Ready),  32'd1);
        checkOutput("mrst_busy",      32'(Busy),      32'd0);
        step(6);
        checkOutput("late_done_valid", 32'(Out_Valid), 32'd0);
        checkOutput("late_done_out_p", Out_P,          32'h0);
        checkOutput("late_done_busy",  32'(Busy),      32'd0);
        checkOutput("late_nstarts",    32'(start_count - base_starts), 32'd0);

        // Stray Done while idle
        spur_p     = 32'hCAFEF00D;
        spur_flags = 6'h2A;
        spur_done  = 1'b1;
        step(1);
        spur_done  = 1'b0;
        step(1);
        checkOutput("idle_spur_valid", 32'(Out_Valid), 32'd0);
        checkOutput("idle_spur_out_p", Out_P,          32'h0);
        checkOutput("idle_spur_flags", 32'(Out_Flags), 32'h0);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
